// File: rtl/bkm_pkg.sv
// Shared types and constants for the BKM sequencer, control step and data step.
package bkm_pkg;

  // Sequencer FSM encoding
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIter = 2'd1,
    StDone = 2'd2
  } seq_state_e;

  // Signed-digit encoding for d_x / d_y, shared with the control and data steps
  localparam logic [1:0] DigitZero = 2'b00;
  localparam logic [1:0] DigitPos  = 2'b01;
  localparam logic [1:0] DigitNeg  = 2'b11;

  // BKM mode codes
  localparam logic ModeE = 1'b0;  // exponential
  localparam logic ModeL = 1'b1;  // logarithm

  // Number format codes
  localparam logic [1:0] FmtFix  = 2'd0;
  localparam logic [1:0] FmtFp32 = 2'd1;
  localparam logic [1:0] FmtFp64 = 2'd2;
  localparam logic [1:0] FmtRsvd = 2'd3;

endpackage

// File: rtl/bkm_seq_counter.sv
// Iteration index counter: clear, advance, global enable and a terminal-count flag
// that asserts when the index equals N_ITER-1. The counter never wraps past N_ITER-1.
module bkm_seq_counter #(
  parameter int unsigned LOG2N  = 6,
  parameter int unsigned N_ITER = 64
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             enable,
  input  logic             clear,
  input  logic             advance,
  output logic [LOG2N-1:0] count,
  output logic             last
);

  localparam logic [LOG2N-1:0] LastIdx = LOG2N'(N_ITER - 1);

  logic [LOG2N-1:0] count_q;

  // Index register; clear beats advance, and advance stops at the last index
  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else if (enable) begin
      if (clear) begin
        count_q <= '0;
      end else if (advance && (count_q != LastIdx)) begin
        count_q <= count_q + LOG2N'(1);
      end
    end
  end

  assign count = count_q;
  assign last  = (count_q == LastIdx);

endmodule

// File: rtl/bkm_iter_sequencer.sv
// Sequences one full BKM run over the combinational bkm_data_step datapath.
// Optional completed-run counter on perf_ops enabled by macro BKM_SEQ_PERF_CNT_EN.
module bkm_iter_sequencer
  import bkm_pkg::*;
#(
  parameter int unsigned W      = 64,
  parameter int unsigned LOG2N  = 6,
  parameter int unsigned N_ITER = 64
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             enable,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [1:0]       in_format,
  input  logic [W-1:0]     in_X0,
  input  logic [W-1:0]     in_Y0,
  input  logic [1:0]       ctl_d_x_n,
  input  logic [1:0]       ctl_d_y_n,
  output logic             step_mode,
  output logic [1:0]       step_format,
  output logic [LOG2N-1:0] step_n,
  output logic [1:0]       step_d_x_n,
  output logic [1:0]       step_d_y_n,
  output logic [W-1:0]     step_X_n,
  output logic [W-1:0]     step_Y_n,
  input  logic [W-1:0]     step_X_np1,
  input  logic [W-1:0]     step_Y_np1,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_X,
  output logic [W-1:0]     out_Y,
  output logic [31:0]      perf_ops
);

  seq_state_e       state_q, state_d;
  logic [W-1:0]     x_q, x_d, y_q, y_d;
  logic             mode_q, mode_d;
  logic [1:0]       format_q, format_d;
  logic             cnt_clr, cnt_adv, cnt_last;
  logic [LOG2N-1:0] cnt;
  logic             handshake;

  bkm_seq_counter #(
    .LOG2N  (LOG2N),
    .N_ITER (N_ITER)
  ) u_counter (
    .clk     (clk),
    .srst    (srst),
    .enable  (enable),
    .clear   (cnt_clr),
    .advance (cnt_adv),
    .count   (cnt),
    .last    (cnt_last)
  );

  // Next-state, operand capture, per-iteration update and handshake outputs
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    mode_d    = mode_q;
    format_d  = format_q;
    cnt_clr   = 1'b0;
    cnt_adv   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    handshake = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d      = in_X0;
          y_d      = in_Y0;
          mode_d   = in_mode;
          format_d = in_format;
          cnt_clr  = 1'b1;
          state_d  = StIter;
        end
      end
      StIter: begin
        // Abort leaves X/Y as they were
        if (abort) begin
          state_d = StIdle;
        end else begin
          x_d = step_X_np1;
          y_d = step_Y_np1;
          if (cnt_last) begin
            state_d = StDone;
          end else begin
            cnt_adv = 1'b1;
          end
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (abort) begin
          state_d = StIdle;
        end else if (out_ready) begin
          handshake = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; enable low freezes everything, abort included
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      mode_q   <= 1'b0;
      format_q <= 2'd0;
    end else if (enable) begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mode_q   <= mode_d;
      format_q <= format_d;
    end
  end

  assign step_mode   = mode_q;
  assign step_format = format_q;
  assign step_n      = cnt;
  assign step_d_x_n  = ctl_d_x_n;
  assign step_d_y_n  = ctl_d_y_n;
  assign step_X_n    = x_q;
  assign step_Y_n    = y_q;
  assign busy        = (state_q != StIdle);
  assign out_X       = x_q;
  assign out_Y       = y_q;

`ifdef BKM_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;

  // Completed-run counter; aborted runs never reach a handshake so are not counted
  always_ff @(posedge clk) begin
    if (srst) begin
      perf_q <= '0;
    end else if (enable && handshake) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_ops = perf_q;
`else
  assign perf_ops = '0;
`endif

endmodule

// File: tb/tb_bkm_iter_sequencer.sv
// Scoreboard bench for bkm_iter_sequencer with a simple +1/+2 datapath model.
module tb_bkm_iter_sequencer;

  localparam int unsigned W      = 16;
  localparam int unsigned LOG2N  = 4;
  localparam int unsigned N_ITER = 16;
`ifdef BKM_SEQ_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             srst, enable, abort;
  logic             in_valid, in_ready, in_mode;
  logic [1:0]       in_format;
  logic [W-1:0]     in_X0, in_Y0;
  logic [1:0]       ctl_d_x_n, ctl_d_y_n;
  logic             step_mode;
  logic [1:0]       step_format;
  logic [LOG2N-1:0] step_n;
  logic [1:0]       step_d_x_n, step_d_y_n;
  logic [W-1:0]     step_X_n, step_Y_n, step_X_np1, step_Y_np1;
  logic             busy, out_valid, out_ready;
  logic [W-1:0]     out_X, out_Y;
  logic [31:0]      perf_ops;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];  // {X_N, Y_N} of each run expected to complete

  // Reference model state, advanced once per clock at the falling edge
  int          phase    = 0;  // 0 idle, 1 iterating, 2 result waiting
  int          mk       = 0;
  logic [W-1:0] mx0, my0;
  logic        mmode;
  logic [1:0]  mfmt;
  int          perf_exp = 0;

  always #5 clk = ~clk;

  // Datapath stand-in
  assign step_X_np1 = step_X_n + 16'd1;
  assign step_Y_np1 = step_Y_n + 16'd2;

  bkm_iter_sequencer #(
    .W      (W),
    .LOG2N  (LOG2N),
    .N_ITER (N_ITER)
  ) dut (
    .clk         (clk),
    .srst        (srst),
    .enable      (enable),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mode     (in_mode),
    .in_format   (in_format),
    .in_X0       (in_X0),
    .in_Y0       (in_Y0),
    .ctl_d_x_n   (ctl_d_x_n),
    .ctl_d_y_n   (ctl_d_y_n),
    .step_mode   (step_mode),
    .step_format (step_format),
    .step_n      (step_n),
    .step_d_x_n  (step_d_x_n),
    .step_d_y_n  (step_d_y_n),
    .step_X_n    (step_X_n),
    .step_Y_n    (step_Y_n),
    .step_X_np1  (step_X_np1),
    .step_Y_np1  (step_Y_np1),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_X       (out_X),
    .out_Y       (out_Y),
    .perf_ops    (perf_ops)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against the model, then advance the model for the coming edge
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(phase != 0));
    chk("in_ready", 32'(in_ready), 32'(phase == 0));
    chk("out_valid", 32'(out_valid), 32'(phase == 2));
    chk("perf_ops", perf_ops, PerfEn ? 32'(perf_exp) : 32'd0);
    chk("d_x_thru", 32'(step_d_x_n), 32'(ctl_d_x_n));
    chk("d_y_thru", 32'(step_d_y_n), 32'(ctl_d_y_n));
    if (phase == 1) begin
      chk("step_n", 32'(step_n), 32'(mk));
      chk("step_X_n", 32'(step_X_n), 32'(16'(mx0 + 16'(mk))));
      chk("step_Y_n", 32'(step_Y_n), 32'(16'(my0 + 16'(2 * mk))));
      chk("step_mode", 32'(step_mode), 32'(mmode));
      chk("step_format", 32'(step_format), 32'(mfmt));
    end
    if (phase == 2) begin
      chk("out_X_hold", 32'(out_X), 32'(16'(mx0 + 16'(N_ITER))));
      chk("out_Y_hold", 32'(out_Y), 32'(16'(my0 + 16'(2 * N_ITER))));
    end
    if (srst) begin
      phase    = 0;
      perf_exp = 0;
    end else if (enable) begin
      case (phase)
        0: if (in_valid) begin
          phase = 1; mk = 0;
          mx0 = in_X0; my0 = in_Y0; mmode = in_mode; mfmt = in_format;
        end
        1: if (abort) phase = 0;
           else if (mk == N_ITER - 1) phase = 2;
           else mk++;
        2: if (abort) phase = 0;
           else if (out_ready) begin
             if (exp_q.size() == 0) begin
               chk("sb_unexpected_result", 32'd1, 32'd0);
             end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               chk("sb_result", {out_X, out_Y}, e);
             end
             perf_exp++;
             phase = 0;
           end
        default: phase = 0;
      endcase
    end
  end

  // Control-step digits change every cycle
  initial begin
    ctl_d_x_n = 2'd0;
    ctl_d_y_n = 2'd0;
    forever begin
      @(posedge clk);
      #1;
      ctl_d_x_n = 2'($urandom);
      ctl_d_y_n = 2'($urandom);
    end
  end

  task automatic check_reset_outputs();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_step_n", 32'(step_n), 32'd0);
    chk("rst_step_X_n", 32'(step_X_n), 32'd0);
    chk("rst_step_Y_n", 32'(step_Y_n), 32'd0);
    chk("rst_mode_fmt", {29'd0, step_mode, step_format}, 32'd0);
    chk("rst_perf_ops", perf_ops, 32'd0);
  endtask

  // One run; freeze/abort/reset points are given as the iteration index (-1 = none)
  task automatic do_run(input logic [W-1:0] x0, input logic [W-1:0] y0, input int ready_delay,
                        input int freeze_at, input int abort_at, input int srst_at,
                        input bit hold_valid);
    int t;
    in_valid  = 1'b1;
    in_X0     = x0;
    in_Y0     = y0;
    in_mode   = 1'($urandom);
    in_format = 2'($urandom);
    out_ready = (ready_delay == 0);
    if (abort_at < 0 && srst_at < 0) exp_q.push_back({16'(x0 + 16'(N_ITER)), 16'(y0 + 16'(2 * N_ITER))});
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk); #1;  // accept edge
    if (!hold_valid) in_valid = 1'b0;
    in_X0 = W'($urandom);
    in_Y0 = W'($urandom);
    for (int c = 0; c < N_ITER; c++) begin
      if (c == freeze_at) begin
        enable = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        enable = 1'b1;
      end
      if (c == abort_at) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        return;
      end
      if (c == srst_at) begin
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        check_reset_outputs();
        return;
      end
      @(posedge clk); #1;
    end
    t = 0;
    while (!out_valid && t < 8) begin
      @(posedge clk); #1; t++;
    end
    chk("out_valid_wait", 32'(out_valid), 32'd1);
    repeat (ready_delay) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;  // handshake edge
  endtask

  initial begin
    srst = 1'b1; enable = 1'b1; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_mode = 1'b0; in_format = 2'd0; in_X0 = '0; in_Y0 = '0;
    repeat (2) begin @(posedge clk); #1; end
    srst = 1'b0;
    check_reset_outputs();

    do_run(16'h0010, 16'h0100, 0, -1, -1, -1, 1'b0);
    do_run(16'h0010, 16'h0100, 5, -1, -1, -1, 1'b1);  // in_valid high through DONE
    do_run(16'h1234, 16'hfff0, 0, -1, -1, -1, 1'b0);  // taken right after return to IDLE
    do_run(16'h0010, 16'h0100, 0, 7, -1, -1, 1'b0);   // freeze at n=7
    do_run(16'h0010, 16'h0100, 0, -1, 9, -1, 1'b0);   // abort at n=9
    repeat (3) begin @(posedge clk); #1; end
    do_run(16'h0010, 16'h0100, 0, -1, -1, 4, 1'b0);   // srst at n=4
    do_run(16'h0010, 16'h0100, 0, -1, -1, -1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      int fz, ab;
      fz = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N_ITER - 1)) : -1;
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, N_ITER - 1)) : -1;
      do_run(W'($urandom), W'($urandom), int'($urandom_range(0, 3)), fz, ab, -1,
             1'($urandom_range(0, 1)));
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (4) begin @(posedge clk); #1; end
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
